instruction_fetch_unit_64_bit: RTL and testbench

//  Fetch stage directly upstream of the 64-bit instruction memory (1024 x 64, word-addressed,

---
 rtl/instruction_fetch_unit_64_bit_if.sv | 45 ++++
 rtl/instruction_fetch_unit_64_bit.sv | 155 +++++++++++++++
 tb/tb_instruction_fetch_unit_64_bit.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_64_bit_if.sv
// Fetch unit bus bundle: control, instruction-memory and decode-side
// signals grouped into one interface with master (fetch) and slave views.
interface instruction_fetch_unit_64_bit_if #(
   parameter int ADDR_W = 10
);
   // control / loader
   logic              Start;
   logic [ADDR_W-1:0] StartPC;
   logic              Stop;
   logic              LoadValid;
   logic [ADDR_W-1:0] LoadAddr;
   logic [63:0]       LoadData;
   logic              Redirect;
   logic [ADDR_W-1:0] RedirectPC;
   // instruction memory
   logic              MemE;
   logic              MemRW;
   logic [63:0]       MemAddr;
   logic [63:0]       MemDataIn;
   logic [63:0]       MemDataOut;
   // decode handshake
   logic              InstrValid;
   logic              InstrReady;
   logic [63:0]       Instr;
   logic [ADDR_W-1:0] InstrPC;
   logic              Busy;

   modport master (
      input  Start, StartPC, Stop,
      input  LoadValid, LoadAddr, LoadData,
      input  Redirect, RedirectPC,
      input  MemDataOut, InstrReady,
      output MemE, MemRW, MemAddr, MemDataIn,
      output InstrValid, Instr, InstrPC, Busy
   );

   modport slave (
      output Start, StartPC, Stop,
      output LoadValid, LoadAddr, LoadData,
      output Redirect, RedirectPC,
      output MemDataOut, InstrReady,
      input  MemE, MemRW, MemAddr, MemDataIn,
      input  InstrValid, Instr, InstrPC, Busy
   );
endinterface

// File: rtl/instruction_fetch_unit_64_bit.sv
// Instruction fetch stage in front of a 64-bit sync-read memory: PC,
// one outstanding read, 2-entry FIFO to decode, and IDLE program loader.
module instruction_fetch_unit_64_bit #(
   parameter int ADDR_W = 10
) (
   input logic                              Clk,
   input logic                              Reset,
   instruction_fetch_unit_64_bit_if.master  bus
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] tag_pc_q, tag_pc_d;
   logic              inflight_q, inflight_d;
   logic              kill_q, kill_d;
   logic [1:0]        count_q, count_d;
   logic [63:0]       data0_q, data0_d;
   logic [63:0]       data1_q, data1_d;
   logic [ADDR_W-1:0] ipc0_q, ipc0_d;
   logic [ADDR_W-1:0] ipc1_q, ipc1_d;

   logic              run;
   logic              pop;
   logic              push;
   logic              flush;
   logic              issue;
   logic [2:0]        occ;
   logic [1:0]        left;

   // handshake, flush and issue decisions for this cycle
   always_comb begin
      run   = (state_q == S_RUN);
      pop   = (count_q != 2'd0) & bus.InstrReady;
      flush = run & (bus.Stop | bus.Redirect);
      occ   = {1'b0, count_q}
            + {2'b00, inflight_q}
            - {2'b00, pop};
      issue = run & ~flush & (occ < 3'd2);
      push  = run & inflight_q & ~kill_q & ~flush;
      left  = count_q - {1'b0, pop};
   end

   // next-state: FSM, PC, outstanding read tag and FIFO contents
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      count_d    = count_q;
      data0_d    = data0_q;
      data1_d    = data1_q;
      ipc0_d     = ipc0_q;
      ipc1_d     = ipc1_q;
      inflight_d = issue;
      tag_pc_d   = issue ? pc_q : tag_pc_q;
      kill_d     = flush ? inflight_q : 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               state_d = S_RUN;
               pc_d    = bus.StartPC;
            end
         end
         S_RUN: begin
            if (bus.Stop) begin
               state_d = S_IDLE;
               count_d = 2'd0;
            end else if (bus.Redirect) begin
               pc_d    = bus.RedirectPC;
               count_d = 2'd0;
            end else begin
               if (issue) begin
                  pc_d = pc_q + PC_ONE;
               end
               if (pop) begin
                  data0_d = data1_q;
                  ipc0_d  = ipc1_q;
               end
               if (push) begin
                  if (left == 2'd0) begin
                     data0_d = bus.MemDataOut;
                     ipc0_d  = tag_pc_q;
                  end else begin
                     data1_d = bus.MemDataOut;
                     ipc1_d  = tag_pc_q;
                  end
               end
               count_d = left + {1'b0, push};
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // state registers, cleared asynchronously by Reset
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         tag_pc_q   <= '0;
         inflight_q <= 1'b0;
         kill_q     <= 1'b0;
         count_q    <= 2'd0;
         data0_q    <= '0;
         data1_q    <= '0;
         ipc0_q     <= '0;
         ipc1_q     <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         tag_pc_q   <= tag_pc_d;
         inflight_q <= inflight_d;
         kill_q     <= kill_d;
         count_q    <= count_d;
         data0_q    <= data0_d;
         data1_q    <= data1_d;
         ipc0_q     <= ipc0_d;
         ipc1_q     <= ipc1_d;
      end
   end

   // outputs; IDLE pass-throughs are forced to reset values while
   // Reset is held so the bus is quiet in the same cycle
   always_comb begin
      bus.MemE       = 1'b0;
      bus.MemRW      = 1'b1;
      bus.MemAddr    = '0;
      bus.MemDataIn  = '0;
      bus.InstrValid = 1'b0;
      bus.Instr      = '0;
      bus.InstrPC    = '0;
      bus.Busy       = 1'b0;
      if (!Reset) begin
         bus.MemDataIn = bus.LoadData;
         if (run) begin
            bus.MemE    = issue;
            bus.MemAddr = {{(64-ADDR_W){1'b0}}, pc_q};
         end else begin
            bus.MemE    = bus.LoadValid;
            bus.MemRW   = ~bus.LoadValid;
            bus.MemAddr = {{(64-ADDR_W){1'b0}}, bus.LoadAddr};
         end
         bus.InstrValid = (count_q != 2'd0);
         bus.Instr      = bus.InstrValid ? data0_q : '0;
         bus.InstrPC    = bus.InstrValid ? ipc0_q : '0;
         bus.Busy       = run;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit_64_bit.sv
// Bench for instruction_fetch_unit_64_bit: memory model, expected-stream
// scoreboard, directed scenarios and a randomized run.
module tb_instruction_fetch_unit_64_bit;

   typedef struct packed {
      logic [9:0]  pc;
      logic [63:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;

   logic [63:0] mem     [1024];
   logic [63:0] ref_mem [1024];
   exp_t        exp_q   [$];

   logic        hold_v = 1'b0;
   logic [63:0] hold_instr;
   logic [9:0]  hold_pc;

   instruction_fetch_unit_64_bit_if #(.ADDR_W(10)) bus ();

   instruction_fetch_unit_64_bit #(.ADDR_W(10)) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // instruction memory: sync read, write when E=1,RW=0
   always @(posedge clk) begin
      if (bus.MemE) begin
         if (bus.MemRW)
            bus.MemDataOut <= mem[bus.MemAddr[9:0]];
         else
            mem[bus.MemAddr[9:0]] <= bus.MemDataIn;
      end
   end

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // expected stream: sequential words from pc onward, wrapping
   task automatic refill(input logic [9:0] pc);
      logic [9:0] a;
      exp_t e;
      exp_q.delete();
      for (int i = 0; i < 1024; i++) begin
         a = pc + 10'(i);
         e.pc = a;
         e.data = ref_mem[a];
         exp_q.push_back(e);
      end
   endtask

   task automatic load(input logic [9:0] a, input logic [63:0] d);
      bus.LoadValid = 1'b1;
      bus.LoadAddr  = a;
      bus.LoadData  = d;
      ref_mem[a]    = d;
      tick();
      bus.LoadValid = 1'b0;
   endtask

   task automatic start(input logic [9:0] pc);
      bus.Start   = 1'b1;
      bus.StartPC = pc;
      refill(pc);
      tick();
      bus.Start = 1'b0;
   endtask

   task automatic redirect(input logic [9:0] pc);
      bus.Redirect   = 1'b1;
      bus.RedirectPC = pc;
      refill(pc);
      tick();
      bus.Redirect = 1'b0;
   endtask

   task automatic stop(input logic also_redirect);
      bus.Stop       = 1'b1;
      bus.Redirect   = also_redirect;
      bus.RedirectPC = 10'($urandom);
      bus.LoadValid  = 1'b0;
      bus.Start      = 1'b0;
      exp_q.delete();
      tick();
      bus.Stop     = 1'b0;
      bus.Redirect = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!bus.InstrValid && n < 20) begin
         tick();
         n++;
      end
      if (!bus.InstrValid) begin
         errors++;
         $display("FAIL %s timeout waiting InstrValid", name);
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_MemE"},       64'(bus.MemE), 64'd0);
      chk({tag, "_MemRW"},      64'(bus.MemRW), 64'd1);
      chk({tag, "_MemAddr"},    bus.MemAddr, 64'd0);
      chk({tag, "_MemDataIn"},  bus.MemDataIn, 64'd0);
      chk({tag, "_InstrValid"}, 64'(bus.InstrValid), 64'd0);
      chk({tag, "_Instr"},      bus.Instr, 64'd0);
      chk({tag, "_InstrPC"},    64'(bus.InstrPC), 64'd0);
      chk({tag, "_Busy"},       64'(bus.Busy), 64'd0);
   endtask

   // monitor: accepted words against the expected stream, plus
   // address range, hold stability and idle-empty properties
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         hold_v = 1'b0;
      end else begin
         if (bus.MemE)
            chk("memaddr_upper", 64'(bus.MemAddr[63:10]), 64'd0);
         if (!bus.Busy)
            chk("idle_empty", 64'(bus.InstrValid), 64'd0);
         if (hold_v) begin
            chk("hold_valid", 64'(bus.InstrValid), 64'd1);
            chk("hold_instr", bus.Instr, hold_instr);
            chk("hold_pc", 64'(bus.InstrPC), 64'(hold_pc));
         end
         if (bus.Busy && bus.InstrValid && bus.InstrReady &&
             !bus.Redirect && !bus.Stop) begin
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_word pc=%0d instr=%h",
                        bus.InstrPC, bus.Instr);
            end else begin
               e = exp_q.pop_front();
               chk("stream_pc", 64'(bus.InstrPC), 64'(e.pc));
               chk("stream_instr", bus.Instr, e.data);
            end
         end
         hold_v = bus.Busy && bus.InstrValid && !bus.InstrReady &&
                  !bus.Redirect && !bus.Stop;
         hold_instr = bus.Instr;
         hold_pc    = bus.InstrPC;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int seg;
      int r;
      bus.Start      = 1'b0;
      bus.StartPC    = '0;
      bus.Stop       = 1'b0;
      bus.LoadValid  = 1'b0;
      bus.LoadAddr   = '0;
      bus.LoadData   = 64'hFFFF_0000_FFFF_0000;
      bus.Redirect   = 1'b0;
      bus.RedirectPC = '0;
      bus.InstrReady = 1'b0;

      // reset state
      #3;
      chk_reset_outs("reset");
      tick();
      rst = 1'b0;
      tick();

      // program image through the loader path
      for (int i = 0; i < 1024; i++)
         load(10'(i), {$urandom, $urandom});
      for (int i = 0; i < 8; i++)
         load(10'(i), 64'h1000 + 64'(i));

      // 1: straight-line fetch and first-word latency
      bus.InstrReady = 1'b1;
      start(10'd0);
      n = 0;
      while (!bus.InstrValid && n < 10) begin
         tick();
         n++;
      end
      chk("start_latency", 64'(n), 64'd2);
      chk("first_instr", bus.Instr, 64'h1000);
      repeat (10) tick();
      stop(1'b0);
      tick();

      // 2: backpressure fills the buffer and stalls fetch
      bus.InstrReady = 1'b0;
      start(10'd0);
      wait_valid("bp");
      chk("bp_first", bus.Instr, 64'h1000);
      repeat (4) tick();
      chk("bp_mem_idle", 64'(bus.MemE), 64'd0);
      chk("bp_instr_held", bus.Instr, 64'h1000);
      bus.InstrReady = 1'b1;
      repeat (8) tick();
      stop(1'b0);

      // 3: redirect with a read in flight
      start(10'd0);
      repeat (4) tick();
      redirect(10'd5);
      wait_valid("redir");
      chk("redir_pc", 64'(bus.InstrPC), 64'd5);
      chk("redir_instr", bus.Instr, ref_mem[5]);
      repeat (3) tick();
      stop(1'b0);

      // 4: PC wrap at the top of the address space
      start(10'd1023);
      wait_valid("wrap");
      chk("wrap_pc0", 64'(bus.InstrPC), 64'd1023);
      tick();
      chk("wrap_pc1", 64'(bus.InstrPC), 64'd0);
      repeat (4) tick();
      stop(1'b0);

      // 5: stop, reload a word, restart on it
      start(10'd0);
      repeat (3) tick();
      stop(1'b0);
      load(10'd3, 64'hDEAD);
      start(10'd3);
      wait_valid("reload");
      chk("reload_instr", bus.Instr, 64'hDEAD);
      chk("reload_pc", 64'(bus.InstrPC), 64'd3);
      repeat (3) tick();
      stop(1'b0);

      // 6: reset with buffered data and a read outstanding
      bus.InstrReady = 1'b0;
      start(10'd0);
      wait_valid("rst_mid");
      #1 rst = 1'b1;
      #1 chk_reset_outs("rst_mid");
      exp_q.delete();
      tick();
      rst = 1'b0;
      repeat (3) tick();
      chk("post_rst_valid", 64'(bus.InstrValid), 64'd0);
      chk("post_rst_busy", 64'(bus.Busy), 64'd0);

      // randomized run against the expected-stream model
      seg = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!bus.Busy) begin
            repeat ($urandom_range(0, 3))
               load(10'($urandom), {$urandom, $urandom});
            start(10'($urandom));
            seg = 0;
         end else begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
               stop(r == 1);
            end else if (r < 6 || seg > 800) begin
               redirect(10'($urandom));
               seg = 0;
            end else begin
               bus.InstrReady = ($urandom_range(0, 3) != 0);
               bus.LoadValid  = ($urandom_range(0, 7) == 0);
               bus.LoadAddr   = 10'($urandom);
               bus.LoadData   = {$urandom, $urandom};
               bus.Start      = ($urandom_range(0, 15) == 0);
               bus.StartPC    = 10'($urandom);
               tick();
               seg++;
            end
         end
      end
      stop(1'b0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
